// File: rtl/execute.sv
// Execute stage: single-cycle ALU plus a 32-iteration restoring divider.
// Shared uop/register types live in execute_pkg, defined here so the file stays self-contained.
package execute_pkg;
    localparam int RV_XLEN = 32;

    typedef logic [RV_XLEN-1:0] t_rv_reg_data;

    typedef enum logic [3:0] {
        OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_SLL, OP_SRL, OP_SRA,
        OP_SLT, OP_SLTU, OP_DIV, OP_DIVU, OP_REM, OP_REMU
    } t_uop;

    typedef enum logic {OP_REG, OP_IMM} t_optype;

    typedef struct packed {
        t_optype      optype;
        t_rv_reg_data opimm;
    } t_src;

    typedef struct packed {
        logic       valid;
        t_uop       uop;
        logic [4:0] rd;
        t_src [1:0] src;
    } t_uinstr;

    function automatic logic is_div(input t_uop u);
        return (u == OP_DIV) || (u == OP_DIVU) || (u == OP_REM) || (u == OP_REMU);
    endfunction
endpackage

module execute
    import execute_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic               clk,
    input  logic               reset,
    input  t_uinstr            uinstr_rd1,
    input  t_rv_reg_data [1:0] rddatas_rd1,
    input  logic               br_mispred_rb1,
    output logic               stall_ex0,
    output t_uinstr            uinstr_ex1,
    output t_rv_reg_data       result_ex1
);
    localparam int SHW = $clog2(XLEN);
    localparam logic [4:0] CNT_LAST = 5'(XLEN - 1);

    typedef enum logic {IDLE, BUSY} t_state;

    t_state            state, state_nxt;
    logic [4:0]        cnt;
    logic [XLEN-1:0]   op1, op2, alu;
    logic [SHW-1:0]    shamt;
    logic              div_req, accept, div_signed;

    t_uinstr           div_uop;
    logic [XLEN-1:0]   dvsr_r, rem_r, quo_r, dividend_r;
    logic              neg_q, neg_r, div_zero, is_rem;
    logic [XLEN:0]     shifted, diff;
    logic              ge;
    logic [XLEN-1:0]   rem_n, quo_n, q_fix, r_fix, div_res;

    assign op1   = (uinstr_rd1.src[0].optype == OP_REG) ? rddatas_rd1[0] : uinstr_rd1.src[0].opimm;
    assign op2   = (uinstr_rd1.src[1].optype == OP_REG) ? rddatas_rd1[1] : uinstr_rd1.src[1].opimm;
    assign shamt = op2[SHW-1:0];

    assign div_req    = uinstr_rd1.valid && is_div(uinstr_rd1.uop);
    assign accept     = (state == IDLE) && div_req && !br_mispred_rb1;
    assign div_signed = (uinstr_rd1.uop == OP_DIV) || (uinstr_rd1.uop == OP_REM);

    always_comb begin
        alu = '0;
        case (uinstr_rd1.uop)
            OP_ADD:  alu = op1 + op2;
            OP_SUB:  alu = op1 - op2;
            OP_AND:  alu = op1 & op2;
            OP_OR:   alu = op1 | op2;
            OP_XOR:  alu = op1 ^ op2;
            OP_SLL:  alu = op1 << shamt;
            OP_SRL:  alu = op1 >> shamt;
            OP_SRA:  alu = $signed(op1) >>> shamt;
            OP_SLT:  alu = {{(XLEN-1){1'b0}}, $signed(op1) < $signed(op2)};
            OP_SLTU: alu = {{(XLEN-1){1'b0}}, op1 < op2};
            default: alu = '0;
        endcase
    end

    // One restoring step on magnitudes; the last step feeds sign fix-up directly.
    always_comb begin
        shifted = {rem_r, quo_r[XLEN-1]};
        diff    = shifted - {1'b0, dvsr_r};
        ge      = !diff[XLEN];
        rem_n   = ge ? diff[XLEN-1:0] : shifted[XLEN-1:0];
        quo_n   = {quo_r[XLEN-2:0], ge};
        q_fix   = neg_q ? (~quo_n + 1'b1) : quo_n;
        r_fix   = neg_r ? (~rem_n + 1'b1) : rem_n;
        if (div_zero) begin
            q_fix = '1;
            r_fix = dividend_r;
        end
        div_res = is_rem ? r_fix : q_fix;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        stall_ex0 = 1'b0;
        case (state)
            IDLE: begin
                if (accept) state_nxt = BUSY;
                stall_ex0 = div_req && !br_mispred_rb1;
            end
            BUSY: begin
                if (br_mispred_rb1 || cnt == CNT_LAST) state_nxt = IDLE;
                stall_ex0 = (cnt != CNT_LAST) && !br_mispred_rb1;
            end
            default: state_nxt = IDLE;
        endcase
        if (reset) stall_ex0 = 1'b0;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt        <= '0;
            uinstr_ex1 <= '0;
            result_ex1 <= '0;
            div_uop    <= '0;
            dvsr_r     <= '0;
            rem_r      <= '0;
            quo_r      <= '0;
            dividend_r <= '0;
            neg_q      <= 1'b0;
            neg_r      <= 1'b0;
            div_zero   <= 1'b0;
            is_rem     <= 1'b0;
        end else begin
            uinstr_ex1.valid <= 1'b0;
            if (!br_mispred_rb1) begin
                if (state == IDLE && uinstr_rd1.valid) begin
                    if (div_req) begin
                        cnt        <= '0;
                        div_uop    <= uinstr_rd1;
                        dividend_r <= op1;
                        rem_r      <= '0;
                        quo_r      <= (div_signed && op1[XLEN-1]) ? (~op1 + 1'b1) : op1;
                        dvsr_r     <= (div_signed && op2[XLEN-1]) ? (~op2 + 1'b1) : op2;
                        neg_q      <= div_signed && (op1[XLEN-1] ^ op2[XLEN-1]);
                        neg_r      <= div_signed && op1[XLEN-1];
                        div_zero   <= (op2 == '0);
                        is_rem     <= (uinstr_rd1.uop == OP_REM) || (uinstr_rd1.uop == OP_REMU);
                    end else begin
                        uinstr_ex1 <= uinstr_rd1;
                        result_ex1 <= alu;
                    end
                end else if (state == BUSY) begin
                    cnt   <= cnt + 1'b1;
                    rem_r <= rem_n;
                    quo_r <= quo_n;
                    if (cnt == CNT_LAST) begin
                        uinstr_ex1 <= div_uop;
                        result_ex1 <= div_res;
                    end
                end
            end
        end
    end

    // Upstream must hold off while the divider is busy; such a uop is ignored.
    assert property (@(posedge clk) disable iff (reset)
        !(state == BUSY && uinstr_rd1.valid && !br_mispred_rb1));

endmodule

// File: tb/tb_execute.sv
// Directed bench for execute: ALU vectors, divider latency/corner cases, flush and mid-divide reset.
module tb_execute;
    import execute_pkg::*;

    logic               clk;
    logic               reset;
    t_uinstr            uinstr_rd1;
    t_rv_reg_data [1:0] rddatas_rd1;
    logic               br_mispred_rb1;
    logic               stall_ex0;
    t_uinstr            uinstr_ex1;
    t_rv_reg_data       result_ex1;

    int total = 0;
    int bad   = 0;

    execute #(.XLEN(32)) dut (
        .clk            (clk),
        .reset          (reset),
        .uinstr_rd1     (uinstr_rd1),
        .rddatas_rd1    (rddatas_rd1),
        .br_mispred_rb1 (br_mispred_rb1),
        .stall_ex0      (stall_ex0),
        .uinstr_ex1     (uinstr_ex1),
        .result_ex1     (result_ex1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    function automatic t_uinstr mk(input t_uop op, input t_optype t1, input logic [31:0] i1,
                                   input t_optype t2, input logic [31:0] i2);
        t_uinstr u;
        u = '0;
        u.valid = 1'b1;
        u.uop = op;
        u.rd = 5'd3;
        u.src[0].optype = t1;
        u.src[0].opimm = i1;
        u.src[1].optype = t2;
        u.src[1].opimm = i2;
        return u;
    endfunction

    task automatic issue(input t_uinstr u, input logic [31:0] a, input logic [31:0] b);
        uinstr_rd1 = u;
        rddatas_rd1[0] = a;
        rddatas_rd1[1] = b;
    endtask

    task automatic idle_in();
        uinstr_rd1 = '0;
        rddatas_rd1 = '0;
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    // ALU vectors: src type selects register data or immediate; unused side gets junk.
    t_uop        aop [12];
    t_optype     at1 [12];
    t_optype     at2 [12];
    logic [31:0] aa  [12];
    logic [31:0] ab  [12];
    logic [31:0] ae  [12];

    t_uop        dop [13];
    logic [31:0] da  [13];
    logic [31:0] db  [13];
    logic [31:0] de  [13];

    initial begin
        aop = '{OP_SUB, OP_AND, OP_OR, OP_XOR, OP_SLL, OP_SRL, OP_SRA, OP_SLT, OP_SLTU, OP_SLT, OP_SLTU, OP_ADD};
        at1 = '{OP_REG, OP_REG, OP_REG, OP_REG, OP_REG, OP_REG, OP_REG, OP_REG, OP_REG, OP_REG, OP_REG, OP_IMM};
        at2 = '{OP_REG, OP_REG, OP_REG, OP_REG, OP_IMM, OP_REG, OP_IMM, OP_REG, OP_REG, OP_REG, OP_REG, OP_REG};
        aa  = '{32'd5, 32'hF0F0F0F0, 32'hF0F0F0F0, 32'hAAAA5555, 32'd1, 32'h80000000, 32'h80000000,
                32'hFFFFFFFF, 32'hFFFFFFFF, 32'd1, 32'd1, 32'h7FFFFFFF};
        ab  = '{32'd7, 32'hFF00FF00, 32'h0F0F0000, 32'hFFFF0000, 32'h21, 32'd4, 32'h24,
                32'd1, 32'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd1};
        ae  = '{32'hFFFFFFFE, 32'hF000F000, 32'hFFFFF0F0, 32'h55555555, 32'd2, 32'h08000000, 32'hF8000000,
                32'd1, 32'd0, 32'd0, 32'd1, 32'h80000000};

        dop = '{OP_DIV, OP_REM, OP_DIVU, OP_REMU, OP_DIV, OP_REM, OP_DIVU, OP_REMU,
                OP_DIV, OP_REM, OP_DIV, OP_REM, OP_DIVU};
        da  = '{32'hFFFFFFF9, 32'hFFFFFFF9, 32'd5, 32'd5, 32'h80000000, 32'h80000000, 32'd100, 32'd100,
                32'd7, 32'd7, 32'hFFFFFFF8, 32'hFFFFFFF8, 32'hFFFFFFFF};
        db  = '{32'd2, 32'd2, 32'd0, 32'd0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd7, 32'd7,
                32'hFFFFFFFE, 32'hFFFFFFFE, 32'd0, 32'd0, 32'd1};
        de  = '{32'hFFFFFFFD, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd5, 32'h80000000, 32'd0, 32'd14, 32'd2,
                32'hFFFFFFFD, 32'd1, 32'hFFFFFFFF, 32'hFFFFFFF8, 32'hFFFFFFFF};
    end

    task automatic run_div(input int k);
        int nbad;
        logic [31:0] held;
        nbad = 0;
        issue(mk(dop[k], OP_REG, 32'h0, OP_REG, 32'h0), da[k], db[k]);
        #1;
        check("div_stall_T", {31'b0, stall_ex0}, 32'd1);
        held = result_ex1;
        step();
        idle_in();
        for (int i = 1; i <= 32; i++) begin
            #1;
            if (uinstr_ex1.valid !== 1'b0) nbad++;
            if (stall_ex0 !== (i <= 31)) nbad++;
            if (result_ex1 !== held) nbad++;
            step();
        end
        check("div_wait_cycles", nbad, 32'd0);
        check("div_valid_T33", {31'b0, uinstr_ex1.valid}, 32'd1);
        check("div_result", result_ex1, de[k]);
        check("div_uop", {28'b0, uinstr_ex1.uop}, {28'b0, dop[k]});
    endtask

    initial begin
        int nbad;
        reset = 1'b1;
        br_mispred_rb1 = 1'b0;
        idle_in();
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_valid", {31'b0, uinstr_ex1.valid}, 32'd0);
        check("rst_result", result_ex1, 32'd0);
        check("rst_stall", {31'b0, stall_ex0}, 32'd0);

        // First uop right after reset release.
        reset = 1'b0;
        issue(mk(OP_ADD, OP_REG, 32'h0, OP_IMM, 32'd1), 32'hFFFFFFFF, 32'h12345678);
        step();
        check("add_wrap_valid", {31'b0, uinstr_ex1.valid}, 32'd1);
        check("add_wrap_result", result_ex1, 32'h00000000);

        for (int i = 0; i < 12; i++) begin
            issue(mk(aop[i], at1[i], (at1[i] == OP_IMM) ? aa[i] : 32'h0BADF00D,
                     at2[i], (at2[i] == OP_IMM) ? ab[i] : 32'h0BADF00D),
                  (at1[i] == OP_REG) ? aa[i] : 32'hDEADBEEF,
                  (at2[i] == OP_REG) ? ab[i] : 32'hDEADBEEF);
            step();
            check($sformatf("alu%0d_valid", i), {31'b0, uinstr_ex1.valid}, 32'd1);
            check($sformatf("alu%0d_result", i), result_ex1, ae[i]);
        end

        idle_in();
        step();
        check("idle_valid", {31'b0, uinstr_ex1.valid}, 32'd0);
        check("idle_hold", result_ex1, 32'h80000000);

        for (int k = 0; k < 13; k++) run_div(k);

        // Flush drops an ALU uop in flight.
        br_mispred_rb1 = 1'b1;
        issue(mk(OP_ADD, OP_REG, 32'h0, OP_REG, 32'h0), 32'd9, 32'd9);
        step();
        br_mispred_rb1 = 1'b0;
        idle_in();
        check("flush_alu_valid", {31'b0, uinstr_ex1.valid}, 32'd0);

        // Flush aborts a divide at T+10.
        nbad = 0;
        issue(mk(OP_DIV, OP_REG, 32'h0, OP_REG, 32'h0), 32'd100, 32'd3);
        step();
        idle_in();
        for (int i = 1; i <= 9; i++) begin
            #1;
            if (uinstr_ex1.valid !== 1'b0) nbad++;
            if (stall_ex0 !== 1'b1) nbad++;
            step();
        end
        br_mispred_rb1 = 1'b1;
        #1;
        check("flush_stall_low", {31'b0, stall_ex0}, 32'd0);
        step();
        br_mispred_rb1 = 1'b0;
        #1;
        if (uinstr_ex1.valid !== 1'b0) nbad++;
        if (stall_ex0 !== 1'b0) nbad++;
        step();
        issue(mk(OP_ADD, OP_REG, 32'h0, OP_REG, 32'h0), 32'd2, 32'd3);
        step();
        idle_in();
        check("post_flush_add_valid", {31'b0, uinstr_ex1.valid}, 32'd1);
        check("post_flush_add_result", result_ex1, 32'd5);
        for (int i = 14; i <= 40; i++) begin
            step();
            if (uinstr_ex1.valid !== 1'b0) nbad++;
        end
        check("flush_quiet_cycles", nbad, 32'd0);

        // Reset pulsed at T+5 of a divide.
        issue(mk(OP_DIVU, OP_REG, 32'h0, OP_REG, 32'h0), 32'd50, 32'd5);
        step();
        idle_in();
        repeat (4) step();
        reset = 1'b1;
        #1;
        check("midrst_stall", {31'b0, stall_ex0}, 32'd0);
        check("midrst_valid", {31'b0, uinstr_ex1.valid}, 32'd0);
        check("midrst_result", result_ex1, 32'd0);
        step();
        reset = 1'b0;
        nbad = 0;
        for (int i = 0; i < 40; i++) begin
            step();
            if (uinstr_ex1.valid !== 1'b0) nbad++;
            if (stall_ex0 !== 1'b0) nbad++;
        end
        check("midrst_quiet", nbad, 32'd0);

        issue(mk(OP_XOR, OP_REG, 32'h0, OP_IMM, 32'h0000FFFF), 32'h12345678, 32'h0);
        step();
        idle_in();
        check("resume_valid", {31'b0, uinstr_ex1.valid}, 32'd1);
        check("resume_result", result_ex1, 32'h1234A987);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
